div_seq: RTL and testbench

Parametrised sequential restoring divider: successor to the fixed 32-bit signed `div` block, using the same `en`/`done` start-and-poll convention. Adds operand-width parametrisation, a per-operation signed/unsigned mode select, quotient and remainder outputs, an explicit busy indication and a divide-by-zero flag. Sits beside the multiplier in the datapath execute stage; the controller pulses `en` and polls `done`.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 28 ++
 rtl/div_seq.sv | 112 +++++++++++
 tb/tb_div_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Operand width used when the instantiating block does not override it.
  localparam int DEF_WIDTH = 32;

  // Sequencer states: wait for a request, iterate, then sign-correct and publish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Counter width needed to hold the value WIDTH (the step count).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Counter width for the default operand width.
  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r, q} left, trial-subtract the
// divisor from the widened partial remainder, keep the difference on no borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  // r < b always holds, so the shifted value fits WIDTH+1 bits and the top
  // bit of the WIDTH+1-bit difference is a clean borrow indicator.
  assign r_sh   = {r, q[WIDTH-1]};
  assign diff   = r_sh - {1'b0, b};
  assign borrow = diff[WIDTH];

  assign r_next = borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Parametrised sequential restoring divider with signed/unsigned mode,
// quotient/remainder outputs, busy indication and divide-by-zero flag.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sgn,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             busy,
  output logic             dbz
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r, q, b_mag, a_orig;
  logic             q_neg, r_neg, zero_div;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH-1:0] r_step, q_step;
  logic             start;

  assign start = (state == IDLE) && en;

  // Operand magnitudes for the unsigned core; MIN maps onto itself as unsigned.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    a_mag_in = opA;
    b_mag_in = opB;
    if (sgn && opA[WIDTH-1]) a_mag_in = -opA;
    if (sgn && opB[WIDTH-1]) b_mag_in = -opB;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .b      (b_mag),
    .r_next (r_step),
    .q_next (q_step)
  );

  // Sequencer and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            busy <= 1'b1;
            if (opB == '0) begin
              state <= FIX;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quo   <= zero_div ? '1 : (q_neg ? -q : q);
          rem   <= zero_div ? a_orig : (r_neg ? -r : r);
          dbz   <= zero_div;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath working registers: loaded on acceptance, stepped during CALC.
  always_ff @(posedge clk) begin
    // NOTE: these are deliberately not reset; they are always reloaded on
    // acceptance before being read, so a reset would only cost wiring.
    if (start) begin
      a_orig   <= opA;
      b_mag    <= b_mag_in;
      q        <= a_mag_in;
      r        <= '0;
      q_neg    <= sgn && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      r_neg    <= sgn && opA[WIDTH-1];
      zero_div <= (opB == '0);
    end else if (state == CALC) begin
      r <= r_step;
      q <= q_step;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at WIDTH=32 and WIDTH=8: stimulus pushes the
// expected result, per-instance monitors pop and compare on each done pulse.
module tb_div_seq;

  typedef struct {
    logic [63:0] quo;
    logic [63:0] rem;
    logic        dbz;
    int          lat;
    int          cap;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  int          cyc = 0;

  logic        en, sgn, done, busy, dbz;
  logic [31:0] opa, opb, quo, rem;

  logic        en8, sgn8, done8, busy8, dbz8;
  logic [7:0]  opa8, opb8, quo8, rem8;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int   n_pass = 0, n_total = 0;
  int   spur32 = 0, spur8 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .nrst(nrst), .en(en), .sgn(sgn), .opA(opa), .opB(opb),
    .quo(quo), .rem(rem), .done(done), .busy(busy), .dbz(dbz)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst), .en(en8), .sgn(sgn8), .opA(opa8), .opB(opb8),
    .quo(quo8), .rem(rem8), .done(done8), .busy(busy8), .dbz(dbz8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    else n_pass++;
  endtask

  // Monitors: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb32.size() == 0) spur32++;
      else begin
        e32 = sb32.pop_front();
        check("quo32", 64'(quo), e32.quo);
        check("rem32", 64'(rem), e32.rem);
        check("dbz32", 64'(dbz), 64'(e32.dbz));
        check("lat32", 64'(cyc - e32.cap), 64'(e32.lat));
        check("busy32_at_done", 64'(busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) spur8++;
      else begin
        e8 = sb8.pop_front();
        check("quo8", 64'(quo8), e8.quo);
        check("rem8", 64'(rem8), e8.rem);
        check("dbz8", 64'(dbz8), 64'(e8.dbz));
        check("lat8", 64'(cyc - e8.cap), 64'(e8.lat));
      end
    end
  end

  // Issue one 32-bit request; operands are scrambled right after capture.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input int lat, input bit push);
    exp_t x;
    @(negedge clk);
    sgn = s; opa = a; opb = b; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; sgn = ~s; opa = $urandom; opb = $urandom;
    check("busy32_after_en", 64'(busy), 64'd1);
    if (push) begin
      x.quo = 64'(eq); x.rem = 64'(er); x.dbz = ed; x.lat = lat; x.cap = cyc;
      sb32.push_back(x);
    end
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ed);
    exp_t x;
    @(negedge clk);
    sgn8 = s; opa8 = a; opb8 = b; en8 = 1'b1;
    @(posedge clk); #1;
    en8 = 1'b0; opa8 = 8'h00; opb8 = 8'h00;
    x.quo = 64'(eq); x.rem = 64'(er); x.dbz = ed; x.lat = 9; x.cap = cyc;
    sb8.push_back(x);
  endtask

  task automatic wait_idle(input bit wide);
    int n = 0;
    while ((wide ? sb32.size() : sb8.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (wide && sb32.size() != 0) begin
      check("timeout32", 64'(sb32.size()), 64'd0);
      sb32.delete();
    end
    if (!wide && sb8.size() != 0) begin
      check("timeout8", 64'(sb8.size()), 64'd0);
      sb8.delete();
    end
  endtask

  task automatic check_zero32(input string tag);
    check({tag, "_quo"},  64'(quo),  64'd0);
    check({tag, "_rem"},  64'(rem),  64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_dbz"},  64'(dbz),  64'd0);
  endtask

  initial begin
    nrst = 1'b0;
    en = 1'b0; sgn = 1'b0; opa = '0; opb = '0;
    en8 = 1'b0; sgn8 = 1'b0; opa8 = '0; opb8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero32("reset");
    check("reset_quo8", 64'(quo8), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Directed 32-bit vectors.
    issue32(1, 32'hFFF0_BDC0, 32'd168, 32'hFFFF_E8C0, 32'hFFFF_FFC0, 0, 33, 1); wait_idle(1);
    issue32(0, 32'hFFF0_BDC0, 32'd168, 32'h0186_0121, 32'd24,       0, 33, 1); wait_idle(1);
    issue32(1, 32'h0000_550B, 32'hFFFF_FFFF, 32'hFFFF_AAF5, 32'd0,  0, 33, 1); wait_idle(1);
    issue32(0, 32'h0000_550B, 32'hFFFF_FFFF, 32'd0, 32'h0000_550B,  0, 33, 1); wait_idle(1);
    issue32(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,  0, 33, 1); wait_idle(1);
    issue32(0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234,  1,  1, 1); wait_idle(1);
    issue32(1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00,  1,  1, 1); wait_idle(1);
    issue32(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,  0, 33, 1); wait_idle(1);

    // A request during CALC is ignored and the result is unaffected.
    issue32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 1);
    repeat (9) @(negedge clk);
    en = 1'b1; sgn = 1'b0; opa = 32'd5; opb = 32'd1;
    check("busy32_mid_op", 64'(busy), 64'd1);
    @(negedge clk);
    en = 1'b0;
    wait_idle(1);

    // Back-to-back: request raised in the done cycle is accepted at the next edge.
    issue32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 1);
    begin
      int n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 100);
      check("b2b_done_seen", 64'(done), 64'd1);
    end
    issue32(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 33, 1);
    wait_idle(1);

    // Reset at step 20 discards the operation and clears the outputs.
    issue32(0, 32'hFFF0_BDC0, 32'd168, 32'd0, 32'd0, 0, 33, 0);
    repeat (19) @(negedge clk);
    nrst = 1'b0;
    @(posedge clk); #1;
    check_zero32("midreset");
    @(negedge clk);
    nrst = 1'b1;
    repeat (45) @(negedge clk);

    // A request coincident with reset is lost.
    nrst = 1'b0; en = 1'b1; sgn = 1'b0; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1;
    check("rst_en_busy", 64'(busy), 64'd0);
    @(negedge clk);
    nrst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("rst_en_busy_after", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Narrow instance.
    issue8(1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0); wait_idle(0);
    issue8(0, 8'hF9, 8'h02, 8'h7C, 8'h01, 0); wait_idle(0);
    issue8(1, 8'h80, 8'hFF, 8'h80, 8'h00, 0); wait_idle(0);

    check("spurious_done32", 64'(spur32), 64'd0);
    check("spurious_done8",  64'(spur8),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
